// File: rtl/mem_arb_pkg.sv
// Shared definitions for the RAM port arbiter: address widths, grant source
// encoding and the core lock state encoding.
package mem_arb_pkg;

  localparam int RAM_AW  = 15;
  localparam int CORE_AW = 24;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VGA  = 2'd1,
    SRC_CORE = 2'd2,
    SRC_PER  = 2'd3
  } src_t;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker between requester a (core) and b (peripheral).
// The last winner loses a tie. favor_b rewrites history so that b wins the
// next tie, used after a lock is force-released.
module mem_arb_rr2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  input  logic favor_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic last_b;

  // pick a winner; on a tie the side that did not win last time goes
  always_comb begin
    gnt_a = en & req_a & (~req_b | last_b);
    gnt_b = en & req_b & (~req_a | ~last_b);
  end

  // last-winner register; reset value lets the core win the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (favor_b) begin
      last_b <= 1'b0;
    end else if (gnt_a) begin
      last_b <= 1'b0;
    end else if (gnt_b) begin
      last_b <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for VGA reads, core reads/writes and peripheral
// writes. VGA has fixed top priority; core and peripheral alternate.
// The core can lock out the peripheral for read-modify-write sequences,
// bounded by LOCK_MAX cycles.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   LK_UNLOCKED | normal arbitration, peripheral eligible
//   LK_LOCKED   | peripheral masked, lock_cnt counts cycles toward LOCK_MAX
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 16,
  parameter int DATA_W   = 16
) (
  input  logic                 clk,
  input  logic                 rstBtn,
  input  logic                 vga_req,
  input  logic [RAM_AW-1:0]    vga_addr,
  output logic                 vga_gnt,
  output logic                 vga_rvalid,
  output logic [DATA_W-1:0]    vga_rdata,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [CORE_AW-1:0]   core_addr,
  input  logic [DATA_W-1:0]    core_wdata,
  input  logic                 core_lock,
  output logic                 core_gnt,
  output logic                 core_rvalid,
  output logic [DATA_W-1:0]    core_rdata,
  output logic                 lock_err,
  input  logic                 per_req,
  input  logic [RAM_AW-1:0]    per_addr,
  input  logic [DATA_W-1:0]    per_wdata,
  output logic                 per_gnt,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [RAM_AW-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  lock_state_t      lock_state;
  logic [CNT_W-1:0] lock_cnt;
  logic             relock_block;
  logic             lock_hit;
  logic             lock_err_q;
  logic             core_oor;
  logic             per_req_eff;
  logic             rr_core;
  logic             rr_per;
  logic             vga_rd_q;
  logic             core_rd_q;
  logic             core_oor_q;
  src_t             src;

  // upper core address bits select space outside the RAM
  assign core_oor    = |core_addr[CORE_AW-1:RAM_AW];
  assign per_req_eff = per_req & (lock_state == LK_UNLOCKED);
  assign lock_hit    = (lock_state == LK_LOCKED) && (lock_cnt == CNT_W'(LOCK_MAX - 1));

  mem_arb_rr2 u_rr (
    .clk     (clk),
    .rst_n   (rstBtn),
    .en      (rstBtn & ~vga_req),
    .req_a   (core_req),
    .req_b   (per_req_eff),
    .favor_b (lock_hit),
    .gnt_a   (rr_core),
    .gnt_b   (rr_per)
  );

  // select this cycle's owner; nothing is granted while reset is held
  always_comb begin
    src = SRC_NONE;
    if (rstBtn && vga_req) begin
      src = SRC_VGA;
    end else if (rr_core) begin
      src = SRC_CORE;
    end else if (rr_per) begin
      src = SRC_PER;
    end
  end

  assign vga_gnt  = (src == SRC_VGA);
  assign core_gnt = (src == SRC_CORE);
  assign per_gnt  = (src == SRC_PER);

  // steer the owner onto the RAM port; out-of-range core accesses never reach it
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (src)
      SRC_VGA: begin
        mem_en   = 1'b1;
        mem_addr = vga_addr;
      end
      SRC_CORE: begin
        if (!core_oor) begin
          mem_en    = 1'b1;
          mem_we    = core_we;
          mem_addr  = core_addr[RAM_AW-1:0];
          mem_wdata = core_wdata;
        end
      end
      SRC_PER: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = per_addr;
        mem_wdata = per_wdata;
      end
      default: ;
    endcase
  end

  // lock FSM with bounded hold; a forced release blocks relock until core_lock drops
  always_ff @(posedge clk or negedge rstBtn) begin
    if (!rstBtn) begin
      lock_state   <= LK_UNLOCKED;
      lock_cnt     <= '0;
      relock_block <= 1'b0;
      lock_err_q   <= 1'b0;
    end else begin
      lock_err_q <= 1'b0;
      if (!core_lock) begin
        relock_block <= 1'b0;
      end
      case (lock_state)
        LK_UNLOCKED: begin
          if (core_gnt && core_lock && !relock_block) begin
            lock_state <= LK_LOCKED;
            lock_cnt   <= '0;
          end
        end
        LK_LOCKED: begin
          if (!core_lock) begin
            lock_state <= LK_UNLOCKED;
            lock_cnt   <= '0;
          end else if (lock_hit) begin
            lock_state   <= LK_UNLOCKED;
            lock_cnt     <= '0;
            lock_err_q   <= 1'b1;
            relock_block <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        default: lock_state <= LK_UNLOCKED;
      endcase
    end
  end

  // remember which read was issued so its data is routed one cycle later
  always_ff @(posedge clk or negedge rstBtn) begin
    if (!rstBtn) begin
      vga_rd_q   <= 1'b0;
      core_rd_q  <= 1'b0;
      core_oor_q <= 1'b0;
    end else begin
      vga_rd_q   <= vga_gnt;
      core_rd_q  <= core_gnt & ~core_we;
      core_oor_q <= core_oor;
    end
  end

  assign lock_err    = lock_err_q;
  assign vga_rvalid  = vga_rd_q;
  assign vga_rdata   = vga_rd_q ? mem_rdata : '0;
  assign core_rvalid = core_rd_q;
  assign core_rdata  = (core_rd_q && !core_oor_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous RAM.
module tb_mem_port_arbiter;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstBtn;
  logic          vga_req;
  logic [14:0]   vga_addr;
  logic          vga_gnt, vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          core_req, core_we, core_lock;
  logic [23:0]   core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          lock_err;
  logic          per_req;
  logic [14:0]   per_addr;
  logic [DW-1:0] per_wdata;
  logic          per_gnt;
  logic          mem_en, mem_we;
  logic [14:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] ram [0:32767];

  int n_chk  = 0;
  int n_pass = 0;
  logic per_seen, err_seen;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LOCK_MAX(16), .DATA_W(DW)) dut (
    .clk(clk), .rstBtn(rstBtn),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_lock(core_lock), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .lock_err(lock_err),
    .per_req(per_req), .per_addr(per_addr), .per_wdata(per_wdata), .per_gnt(per_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [14:0] va,
                       input logic c, input logic cwe, input logic [23:0] ca,
                       input logic [15:0] cwd, input logic cl,
                       input logic p, input logic [14:0] pa, input logic [15:0] pwd);
    vga_req = v;  vga_addr = va;
    core_req = c; core_we = cwe; core_addr = ca; core_wdata = cwd; core_lock = cl;
    per_req = p;  per_addr = pa; per_wdata = pwd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // inputs change on the falling edge; checks follow 3 time units later
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = '0;
    ram[15'h0010] = 16'hBEEF;
    ram[15'h0020] = 16'h5A5A;

    // reset with every request asserted
    rstBtn = 1'b0;
    drive(1, 15'h10, 1, 1, 24'h20, 16'h7777, 1, 1, 15'h30, 16'h1234);
    repeat (2) @(posedge clk);
    tick(); #3;
    check("rst_ctrl", {vga_gnt, core_gnt, per_gnt, mem_en, mem_we, vga_rvalid, core_rvalid, lock_err}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", {vga_rdata, core_rdata}, 0);

    // three requesters together, first cycle out of reset
    tick(); rstBtn = 1'b1;
    drive(1, 15'h10, 1, 0, 24'h20, 0, 0, 1, 15'h30, 16'h1234); #3;
    check("3way_c0_gnt", {vga_gnt, core_gnt, per_gnt}, 3'b100);
    check("3way_c0_mem", {mem_en, mem_we, 1'b0, mem_addr}, {1'b1, 1'b0, 1'b0, 15'h10});
    tick(); drive(0, 0, 1, 0, 24'h20, 0, 0, 1, 15'h30, 16'h1234); #3;
    check("3way_c1_gnt", {vga_gnt, core_gnt, per_gnt}, 3'b010);
    check("3way_c1_mem", {mem_en, mem_we, 1'b0, mem_addr}, {1'b1, 1'b0, 1'b0, 15'h20});
    check("3way_vga_rd", {vga_rvalid, vga_rdata}, {1'b1, 16'hBEEF});
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 15'h30, 16'h1234); #3;
    check("3way_c2_gnt", {vga_gnt, core_gnt, per_gnt}, 3'b001);
    check("3way_c2_mem", {mem_en, mem_we, 1'b0, mem_addr, mem_wdata}, {1'b1, 1'b1, 1'b0, 15'h30, 16'h1234});
    check("3way_core_rd", {core_rvalid, core_rdata}, {1'b1, 16'h5A5A});
    tick(); idle(); #3;
    check("3way_rvalid_drop", {vga_rvalid, core_rvalid}, 0);

    // core reads, back to back
    tick(); drive(0, 0, 1, 0, 24'h000010, 0, 0, 0, 0, 0); #3;
    check("rd_gnt", {core_gnt, mem_en, mem_we, 1'b0, mem_addr}, {1'b1, 1'b1, 1'b0, 1'b0, 15'h10});
    tick(); drive(0, 0, 1, 0, 24'h000030, 0, 0, 0, 0, 0); #3;
    check("rd_b2b_gnt", core_gnt, 1);
    check("rd_beef", {core_rvalid, core_rdata}, {1'b1, 16'hBEEF});
    tick(); idle(); #3;
    check("rd_per_written", {core_rvalid, core_rdata}, {1'b1, 16'h1234});

    // out-of-range core address
    tick(); drive(0, 0, 1, 1, 24'h010000, 16'hFFFF, 0, 0, 0, 0); #3;
    check("oor_wr", {core_gnt, mem_en, mem_we}, 3'b100);
    tick(); drive(0, 0, 1, 0, 24'h010000, 0, 0, 0, 0, 0); #3;
    check("oor_rd", {core_gnt, mem_en, core_rvalid}, 3'b100);
    tick(); idle(); #3;
    check("oor_rdata", {core_rvalid, core_rdata}, {1'b1, 16'h0000});
    check("oor_nowrite", ram[0], 0);

    // peripheral write leaves the peripheral as last winner
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 15'h40, 16'hCAFE); #3;
    check("per_wr", per_gnt, 1);

    // lock held past LOCK_MAX
    tick(); drive(0, 0, 1, 0, 24'h10, 0, 1, 1, 15'h41, 16'h1111); #3;
    check("lock_take", {core_gnt, per_gnt}, 2'b10);
    per_seen = 1'b0; err_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(); drive(0, 0, 0, 0, 0, 0, 1, 1, 15'h41, 16'h1111); #3;
      per_seen |= per_gnt;
      err_seen |= lock_err;
    end
    check("lock_per_held", per_seen, 0);
    check("lock_err_early", err_seen, 0);
    tick(); drive(0, 0, 1, 0, 24'h10, 0, 1, 1, 15'h41, 16'h1111); #3;
    check("lock_forced", {core_gnt, per_gnt, lock_err}, 3'b011);
    tick(); drive(0, 0, 1, 0, 24'h10, 0, 1, 0, 0, 0); #3;
    check("lock_err_pulse", {core_gnt, lock_err}, 2'b10);
    tick(); drive(0, 0, 0, 0, 0, 0, 1, 1, 15'h42, 16'h2222); #3;
    check("relock_blocked", per_gnt, 1);
    tick(); idle(); #3;

    // normal lock entry, VGA during lock, release by core_lock
    tick(); drive(0, 0, 1, 0, 24'h10, 0, 1, 1, 15'h43, 16'h3333); #3;
    check("lock2_take", {core_gnt, per_gnt}, 2'b10);
    tick(); drive(1, 15'h10, 0, 0, 0, 0, 1, 1, 15'h43, 16'h3333); #3;
    check("lock2_vga", {vga_gnt, core_gnt, per_gnt}, 3'b100);
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 15'h43, 16'h3333); #3;
    check("lock2_still", per_gnt, 0);
    tick(); drive(0, 0, 0, 0, 0, 0, 0, 1, 15'h43, 16'h3333); #3;
    check("lock2_released", per_gnt, 1);
    tick(); idle(); #3;

    // reset right after a core read grant
    tick(); drive(0, 0, 1, 0, 24'h10, 0, 0, 0, 0, 0); #3;
    check("rstmid_gnt", core_gnt, 1);
    @(posedge clk); #1 rstBtn = 1'b0;
    tick(); #3;
    check("rstmid_ctrl", {vga_gnt, core_gnt, per_gnt, mem_en, mem_we, vga_rvalid, core_rvalid, lock_err}, 0);
    check("rstmid_bus", {mem_addr, mem_wdata, core_rdata}, 0);
    tick(); rstBtn = 1'b1; idle(); #3;
    check("rstmid_after", core_rvalid, 0);

    // VGA held continuously
    for (int i = 0; i < 5; i++) begin
      tick(); drive(1, 15'h10, 1, 0, 24'h20, 0, 0, 1, 15'h50, 16'h5555); #3;
      check("vga_hold", {vga_gnt, core_gnt, per_gnt}, 3'b100);
      if (i > 0) check("vga_hold_rd", {vga_rvalid, vga_rdata}, {1'b1, 16'hBEEF});
    end
    tick(); idle(); #3;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
